// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared multdiv state encoding, width default, INT_MIN and result-ready pulse polarity
package div_seq_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic [WIDTH_DEF-1:0] INT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};
    localparam logic RDY_ACTIVE = 1'b1;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/div_addsub.sv
// div_addsub: N-bit a-b built from 8-bit carry-lookahead groups (a, b in; diff, no_borrow out)
module div_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         no_borrow
);
    logic [N-1:0] g, p, c;
    logic cin, gg, pp;
    assign g = a & ~b;
    assign p = a ^ ~b;
    always_comb begin
        c = '0;
        cin = 1'b1;
        gg = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < N; i++) begin
            c[i] = gg | (pp & cin);
            gg = g[i] | (p[i] & gg);
            pp = pp & p[i];
            if (i % 8 == 7 || i == N - 1) begin
                cin = gg | (pp & cin);
                gg = 1'b0;
                pp = 1'b1;
            end
        end
    end
    assign diff = p ^ c;
    assign no_borrow = cin;
endmodule

// File: rtl/div_seq.sv
// div_seq: restoring signed divider (clock, reset, ctrl_DIV, operandA/B in; result, remainder, exception, resultRDY out)
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);
    localparam logic [WIDTH-1:0] min_val = {INT_MIN[WIDTH_DEF-1], {(WIDTH-1){1'b0}}};
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q, abs_a, abs_b, neg_q;
    logic [WIDTH:0] r, d, r_sh, sub_a, sub_b, diff;
    logic sign_q, sign_r, ovf, b_zero, no_borrow, nb_unused;
    assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign b_zero = data_operandB == '0;
    assign r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
    assign sub_a = state == FIX ? '0 : r_sh;
    assign sub_b = state == FIX ? r : d;
    assign data_resultRDY = state == DONE ? RDY_ACTIVE : ~RDY_ACTIVE;
    div_addsub #(.N(WIDTH + 1)) u_sub (
        .a(sub_a),
        .b(sub_b),
        .diff(diff),
        .no_borrow(no_borrow)
    );
    div_addsub #(.N(WIDTH)) u_neg (
        .a('0),
        .b(q),
        .diff(neg_q),
        .no_borrow(nb_unused)
    );
    always_comb begin
        state_n = ctrl_DIV ? (b_zero ? DONE : RUN)
                : state == RUN ? (cnt == CNT_W'(1) ? FIX : RUN)
                : state == FIX ? DONE : IDLE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            q <= '0;
            r <= '0;
            d <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            ovf <= 1'b0;
            data_result <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
        end else if (ctrl_DIV) begin
            cnt <= CNT_W'(WIDTH);
            q <= abs_a;
            r <= '0;
            d <= {1'b0, abs_b};
            sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            sign_r <= data_operandA[WIDTH-1];
            ovf <= data_operandA == min_val && &data_operandB;
            if (b_zero) begin
                data_result <= '0;
                data_remainder <= '0;
                data_exception <= 1'b1;
            end
        end else if (state == RUN) begin
            cnt <= cnt - CNT_W'(1);
            q <= {q[WIDTH-2:0], no_borrow};
            r <= no_borrow ? diff : r_sh;
        end else if (state == FIX) begin
            data_result <= ovf ? min_val : sign_q ? neg_q : q;
            data_remainder <= ovf ? '0 : sign_r ? diff[WIDTH-1:0] : r[WIDTH-1:0];
            data_exception <= ovf;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized and directed self-checking bench for div_seq against an arithmetic reference
module tb_div_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result, data_remainder;
    logic data_exception, data_resultRDY;
    int errors = 0;
    int checks = 0;
    div_seq dut (
        .clock(clock),
        .reset(reset),
        .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .data_result(data_result),
        .data_remainder(data_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );
    always #5 clock = ~clock;
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = '0;
            r = '0;
            e = 1'b1;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            e = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end
    endtask
    task automatic wait_rdy(output int lat);
        lat = 1;
        while (!data_resultRDY && lat < 60) begin
            @(negedge clock);
            lat++;
        end
    endtask
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] eq, er;
        logic ee;
        int lat, el;
        model(a, b, eq, er, ee);
        el = (b == 32'd0) ? 1 : 34;
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        wait_rdy(lat);
        checks++;
        if (lat !== el) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, el);
        end
        checks++;
        if (data_result !== eq) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, data_result, eq);
        end
        checks++;
        if (data_remainder !== er) begin
            errors++;
            $display("FAIL %s remainder: got %h expected %h", name, data_remainder, er);
        end
        checks++;
        if (data_exception !== ee) begin
            errors++;
            $display("FAIL %s exception: got %b expected %b", name, data_exception, ee);
        end
        @(negedge clock);
        checks++;
        if (data_resultRDY !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse width: rdy got %b expected 0", name, data_resultRDY);
        end
    endtask
    task automatic test_reset();
        #2;
        checks++;
        if ({data_result, data_remainder, data_exception, data_resultRDY} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %h/%h/%b/%b expected all 0",
                     data_result, data_remainder, data_exception, data_resultRDY);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask
    task automatic test_directed();
        do_div(32'd100, 32'd7, "100/7");
        do_div(-32'sd100, 32'd7, "-100/7");
        do_div(32'd100, -32'sd7, "100/-7");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, "min/-1");
        do_div(32'h8000_0000, 32'd2, "min/2");
    endtask
    task automatic test_div_zero();
        do_div(32'd12345, 32'd0, "12345/0");
        do_div(32'd9, 32'd3, "9/3");
    endtask
    task automatic test_restart();
        int pulses, lat;
        pulses = 0;
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd10;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
        end
        ctrl_DIV = 1'b1;
        data_operandA = 32'd81;
        data_operandB = 32'd9;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_rdy(lat);
        checks++;
        if (pulses !== 0 || lat !== 34) begin
            errors++;
            $display("FAIL restart timing: early pulses %0d latency %0d expected 0 and 34", pulses, lat);
        end
        checks++;
        if (data_result !== 32'd9 || data_remainder !== 32'd0 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL restart value: got %h/%h/%b expected 00000009/00000000/0",
                     data_result, data_remainder, data_exception);
        end
    endtask
    task automatic test_back_to_back();
        int lat;
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_rdy(lat);
        checks++;
        if (lat !== 34 || data_result !== 32'd10) begin
            errors++;
            $display("FAIL b2b first: latency %0d result %h expected 34 and 0000000a", lat, data_result);
        end
        ctrl_DIV = 1'b1;
        data_operandA = 32'd64;
        data_operandB = -32'sd8;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_rdy(lat);
        checks++;
        if (lat !== 34 || data_result !== 32'hFFFF_FFF8 || data_remainder !== 32'd0) begin
            errors++;
            $display("FAIL b2b second: latency %0d result %h rem %h expected 34 fffffff8 00000000",
                     lat, data_result, data_remainder);
        end
    endtask
    task automatic test_async_reset();
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd10;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (10) @(negedge clock);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({data_result, data_remainder, data_exception, data_resultRDY} !== '0) begin
            errors++;
            $display("FAIL async reset: got %h/%h/%b/%b expected all 0",
                     data_result, data_remainder, data_exception, data_resultRDY);
        end
        @(negedge clock);
        reset = 1'b0;
        do_div(32'd7, 32'd7, "7/7 after reset");
    endtask
    task automatic test_output_hold();
        do_div(-32'sd37, 32'd5, "-37/5");
        repeat (5) begin
            @(negedge clock);
            data_operandA = $urandom;
            data_operandB = $urandom;
        end
        checks++;
        if (data_result !== 32'hFFFF_FFF9 || data_remainder !== 32'hFFFF_FFFE || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL output hold: got %h/%h/%b expected fffffff9/fffffffe/0",
                     data_result, data_remainder, data_exception);
        end
    endtask
    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = (i % 6 == 0) ? 32'h8000_0000 : (i % 5 == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 20));
                2: b = (i % 8 == 2) ? 32'd0 : 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (i % 4 != 2 && $urandom_range(0, 1) == 1) b = -b;
            do_div(a, b, $sformatf("rand%0d %h/%h", i, a, b));
        end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_restart();
        test_back_to_back();
        test_async_reset();
        test_output_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
